// File: rtl/stack_ctrl_if.sv
// Stack controller bus: request/operand signals from the control unit plus the
// stack-pointer and scratch-RAM strobes back out of the controller.
interface stack_ctrl_if #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned SP_W   = 8
);
    logic              SC_START;
    logic [2:0]        SC_OP;
    logic [7:0]        SC_DIN_REG;
    logic [DATA_W-1:0] SC_PC;
    logic [SP_W-1:0]   SC_SP;
    logic              SC_SP_INC;
    logic              SC_SP_DEC;
    logic              SC_SP_LD;
    logic [SP_W-1:0]   SC_SP_DIN;
    logic [SP_W-1:0]   SC_SCR_ADDR;
    logic              SC_SCR_WE;
    logic [DATA_W-1:0] SC_SCR_WDATA;
    logic [DATA_W-1:0] SC_SCR_RDATA;
    logic              SC_CLR_ERR;
    logic              SC_BUSY;
    logic              SC_DONE;
    logic [DATA_W-1:0] SC_RDATA_OUT;
    logic              SC_RDATA_VLD;
    logic              SC_OVF;
    logic              SC_UNF;

    modport slave (
        input  SC_START, SC_OP, SC_DIN_REG, SC_PC, SC_SP, SC_SCR_RDATA, SC_CLR_ERR,
        output SC_SP_INC, SC_SP_DEC, SC_SP_LD, SC_SP_DIN, SC_SCR_ADDR, SC_SCR_WE,
               SC_SCR_WDATA, SC_BUSY, SC_DONE, SC_RDATA_OUT, SC_RDATA_VLD,
               SC_OVF, SC_UNF
    );

    modport master (
        output SC_START, SC_OP, SC_DIN_REG, SC_PC, SC_SP, SC_SCR_RDATA, SC_CLR_ERR,
        input  SC_SP_INC, SC_SP_DEC, SC_SP_LD, SC_SP_DIN, SC_SCR_ADDR, SC_SCR_WE,
               SC_SCR_WDATA, SC_BUSY, SC_DONE, SC_RDATA_OUT, SC_RDATA_VLD,
               SC_OVF, SC_UNF
    );
endinterface

// File: rtl/stack_ctrl.sv
// RAT CPU stack sequencer: PUSH/POP/CALL/RET/LDSP against SP and scratch RAM.
// Define STACK_CTRL_GUARD_EN to enable overflow/underflow protection and flags.
module stack_ctrl #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned SP_W   = 8
) (
    input logic        SC_CLK,
    input logic        SC_RST,
    stack_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH,
        S_POP_ADDR,
        S_POP_CAP,
        S_POP_DONE,
        S_LOAD,
        S_NOP_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_LDSP = 3'd5
    } op_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        din_q, din_d;
    logic [SP_W:0]     occ_q, occ_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              unf_pend_q, unf_pend_d;

    op_t               op_in;
    logic              full;
    logic              empty;
    logic              ovf_err;
    logic              unf_err;
    logic [SP_W-1:0]   ldsp_sp;
    logic [SP_W-1:0]   ldsp_occ;

    assign op_in = op_t'(bus.SC_OP);

`ifdef STACK_CTRL_GUARD_EN
    localparam logic [SP_W:0] OCC_FULL = {1'b1, {SP_W{1'b0}}};
    assign full  = (occ_q == OCC_FULL);
    assign empty = (occ_q == '0);
`else
    // Without the guard the stack never refuses an op, so flags can never set.
    assign full  = 1'b0;
    assign empty = 1'b0;
`endif

    always_ff @(posedge SC_CLK or posedge SC_RST) begin
        if (SC_RST) begin
            state_q    <= S_IDLE;
            wdata_q    <= '0;
            din_q      <= '0;
            occ_q      <= '0;
            rdata_q    <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            unf_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wdata_q    <= wdata_d;
            din_q      <= din_d;
            occ_q      <= occ_d;
            rdata_q    <= rdata_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            unf_pend_q <= unf_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wdata_d    = wdata_q;
        din_d      = din_q;
        occ_d      = occ_q;
        rdata_d    = rdata_q;
        unf_pend_d = unf_pend_q;
        ovf_err    = 1'b0;
        unf_err    = 1'b0;
        ldsp_sp    = SP_W'(din_q);
        ldsp_occ   = '0 - ldsp_sp;

        unique case (state_q)
            S_IDLE: begin
                if (bus.SC_START) begin
                    wdata_d = (op_in == OP_CALL) ? bus.SC_PC : DATA_W'(bus.SC_DIN_REG);
                    din_d   = bus.SC_DIN_REG;
                    case (op_in)
                        OP_PUSH, OP_CALL: state_d = S_PUSH;
                        OP_POP,  OP_RET:  state_d = S_POP_ADDR;
                        OP_LDSP:          state_d = S_LOAD;
                        default:          state_d = S_NOP_DONE;
                    endcase
                end
            end
            S_PUSH: begin
                if (full) ovf_err = 1'b1;
                else      occ_d   = occ_q + 1'b1;
                state_d = S_IDLE;
            end
            S_POP_ADDR: begin
                // Remember a refused pop so the capture stage returns zero.
                unf_pend_d = empty;
                if (empty) unf_err = 1'b1;
                else       occ_d   = occ_q - 1'b1;
                state_d = S_POP_CAP;
            end
            S_POP_CAP: begin
                rdata_d = unf_pend_q ? '0 : bus.SC_SCR_RDATA;
                state_d = S_POP_DONE;
            end
            S_POP_DONE: state_d = S_IDLE;
            S_LOAD: begin
                occ_d   = {1'b0, ldsp_occ};
                state_d = S_IDLE;
            end
            S_NOP_DONE: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        ovf_d = (bus.SC_CLR_ERR ? 1'b0 : ovf_q) | ovf_err;
        unf_d = (bus.SC_CLR_ERR ? 1'b0 : unf_q) | unf_err;
    end

    always_comb begin
        bus.SC_SP_INC    = 1'b0;
        bus.SC_SP_DEC    = 1'b0;
        bus.SC_SP_LD     = 1'b0;
        bus.SC_SP_DIN    = '0;
        bus.SC_SCR_ADDR  = '0;
        bus.SC_SCR_WE    = 1'b0;
        bus.SC_SCR_WDATA = '0;
        bus.SC_DONE      = 1'b0;
        bus.SC_RDATA_VLD = 1'b0;

        unique case (state_q)
            S_PUSH: begin
                bus.SC_SCR_ADDR  = bus.SC_SP - SP_W'(1);
                bus.SC_SCR_WE    = ~full;
                bus.SC_SCR_WDATA = wdata_q;
                bus.SC_SP_DEC    = ~full;
                bus.SC_DONE      = 1'b1;
            end
            S_POP_ADDR: begin
                bus.SC_SCR_ADDR = bus.SC_SP;
                bus.SC_SP_INC   = ~empty;
            end
            S_POP_DONE: begin
                bus.SC_DONE      = 1'b1;
                bus.SC_RDATA_VLD = 1'b1;
            end
            S_LOAD: begin
                bus.SC_SP_LD  = 1'b1;
                bus.SC_SP_DIN = ldsp_sp;
                bus.SC_DONE   = 1'b1;
            end
            S_NOP_DONE: bus.SC_DONE = 1'b1;
            default: ;
        endcase
    end

    assign bus.SC_BUSY      = (state_q != S_IDLE);
    assign bus.SC_RDATA_OUT = rdata_q;
    assign bus.SC_OVF       = ovf_q;
    assign bus.SC_UNF       = unf_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: SP register and scratch RAM are modelled around the DUT,
// and every cycle is checked against an abstract stack model.
module tb_stack_ctrl;
    localparam int DATA_W = 10;
    localparam int SP_W   = 8;
`ifdef STACK_CTRL_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic ram_init;
    logic [7:0] sp_reg;
    logic [DATA_W-1:0] ram [256];

    int tests = 0;
    int fails = 0;

    // Abstract model: stack as an array indexed by SP, plus a plain occupancy count.
    int         m_sp;
    int         m_occ;
    bit         m_ovf;
    bit         m_unf;
    logic [9:0] m_mem [256];
    logic [9:0] m_last;

    always #5 clk = ~clk;

    stack_ctrl_if #(.DATA_W(DATA_W), .SP_W(SP_W)) bus ();

    stack_ctrl #(.DATA_W(DATA_W), .SP_W(SP_W)) dut (
        .SC_CLK (clk),
        .SC_RST (rst),
        .bus    (bus)
    );

    assign bus.SC_SP = sp_reg;

    always @(posedge clk or posedge rst) begin
        if (rst)                sp_reg <= 8'h00;
        else if (bus.SC_SP_LD)  sp_reg <= bus.SC_SP_DIN;
        else if (bus.SC_SP_INC) sp_reg <= sp_reg + 8'd1;
        else if (bus.SC_SP_DEC) sp_reg <= sp_reg - 8'd1;
    end

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= 10'(i * 37 + 5);
        end else if (bus.SC_SCR_WE) begin
            ram[bus.SC_SCR_ADDR] <= bus.SC_SCR_WDATA;
        end
        bus.SC_SCR_RDATA <= ram[bus.SC_SCR_ADDR];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input bit busy, input bit done, input bit vld,
                            input bit we, input bit dec, input bit inc, input bit ld,
                            input int addr, input int wdata, input int spdin);
        chk({tag, "/busy"},  32'(bus.SC_BUSY),      32'(busy));
        chk({tag, "/done"},  32'(bus.SC_DONE),      32'(done));
        chk({tag, "/vld"},   32'(bus.SC_RDATA_VLD), 32'(vld));
        chk({tag, "/we"},    32'(bus.SC_SCR_WE),    32'(we));
        chk({tag, "/dec"},   32'(bus.SC_SP_DEC),    32'(dec));
        chk({tag, "/inc"},   32'(bus.SC_SP_INC),    32'(inc));
        chk({tag, "/ld"},    32'(bus.SC_SP_LD),     32'(ld));
        chk({tag, "/addr"},  32'(bus.SC_SCR_ADDR),  32'(addr));
        chk({tag, "/wdata"}, 32'(bus.SC_SCR_WDATA), 32'(wdata));
        chk({tag, "/spdin"}, 32'(bus.SC_SP_DIN),    32'(spdin));
    endtask

    task automatic chk_idle(input string tag);
        chk_outs({tag, "/idle"}, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk({tag, "/rdata"}, 32'(bus.SC_RDATA_OUT), 32'(m_last));
        chk({tag, "/ovf"},   32'(bus.SC_OVF),       32'(m_ovf));
        chk({tag, "/unf"},   32'(bus.SC_UNF),       32'(m_unf));
        chk({tag, "/sp"},    32'(sp_reg),           32'(m_sp));
    endtask

    // Issues one op at a negedge; clr_mode 1 = CLR_ERR on the accept edge,
    // 2 = CLR_ERR on the first busy cycle; spam keeps START high into that cycle.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] din,
                          input logic [9:0] pc, input int clr_mode, input bit spam);
        bit is_push, is_pop, is_ldsp, err;
        int addr;
        logic [9:0] w;
        is_push = (op == 3'd1) || (op == 3'd3);
        is_pop  = (op == 3'd2) || (op == 3'd4);
        is_ldsp = (op == 3'd5);
        bus.SC_START   = 1'b1;
        bus.SC_OP      = op;
        bus.SC_DIN_REG = din;
        bus.SC_PC      = pc;
        bus.SC_CLR_ERR = (clr_mode == 1);
        @(negedge clk);
        if (clr_mode != 0) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (is_push) begin
            w    = (op == 3'd3) ? pc : {2'b00, din};
            addr = (m_sp + 255) % 256;
            err  = GUARD && (m_occ == 256);
            chk_outs({tag, "/push"}, 1, 1, 0, !err, !err, 0, 0, addr, w, 0);
            if (err) m_ovf = 1'b1;
            else begin
                m_mem[addr] = w;
                m_sp  = addr;
                m_occ = (m_occ + 1) % 512;
            end
        end else if (is_pop) begin
            err = GUARD && (m_occ == 0);
            chk_outs({tag, "/pop_addr"}, 1, 0, 0, 0, 0, !err, 0, m_sp, 0, 0);
        end else if (is_ldsp) begin
            chk_outs({tag, "/ldsp"}, 1, 1, 0, 0, 0, 0, 1, 0, 0, din);
            m_sp  = din;
            m_occ = (256 - din) % 256;
        end else begin
            chk_outs({tag, "/nop"}, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        bus.SC_START   = spam;
        bus.SC_OP      = spam ? 3'd1 : op;
        bus.SC_CLR_ERR = (clr_mode == 2);
        if (is_pop) begin
            @(negedge clk);
            bus.SC_START   = 1'b0;
            bus.SC_CLR_ERR = 1'b0;
            chk_outs({tag, "/pop_cap"}, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            m_last = err ? 10'd0 : m_mem[m_sp];
            chk_outs({tag, "/pop_done"}, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
            chk({tag, "/pop_rdata"}, 32'(bus.SC_RDATA_OUT), 32'(m_last));
            if (err) m_unf = 1'b1;
            else begin
                m_sp  = (m_sp + 1) % 256;
                m_occ = (m_occ + 511) % 512;
            end
        end
        @(negedge clk);
        bus.SC_START   = 1'b0;
        bus.SC_CLR_ERR = 1'b0;
        chk_idle(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        ram_init       = 1'b1;
        bus.SC_START   = 1'b0;
        bus.SC_OP      = 3'd0;
        bus.SC_DIN_REG = 8'h00;
        bus.SC_PC      = '0;
        bus.SC_CLR_ERR = 1'b0;
        for (int i = 0; i < 256; i++) m_mem[i] = 10'(i * 37 + 5);
        m_sp = 0; m_occ = 0; m_ovf = 1'b0; m_unf = 1'b0; m_last = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        rst      = 1'b0;
        ram_init = 1'b0;
        @(negedge clk);

        run_op("push5a", 3'd1, 8'h5A, 10'h000, 0, 1'b0);
        run_op("call",   3'd3, 8'h00, 10'h3A7, 0, 1'b0);
        run_op("ret",    3'd4, 8'h00, 10'h000, 0, 1'b0);
        run_op("pop_spam", 3'd2, 8'h00, 10'h000, 0, 1'b1);

        run_op("ldsp_f0", 3'd5, 8'hF0, 10'h000, 0, 1'b0);
        for (int i = 0; i < 16; i++) run_op("pop16", 3'd2, 8'h00, 10'h000, 0, 1'b0);
        run_op("pop17", 3'd2, 8'h00, 10'h000, 0, 1'b0);
        run_op("clr_unf", 3'd0, 8'h00, 10'h000, 1, 1'b0);

        run_op("ldsp_00", 3'd5, 8'h00, 10'h000, 0, 1'b0);
        for (int i = 0; i < 256; i++) run_op("push256", 3'd1, 8'($urandom), 10'h000, 0, 1'b0);
        run_op("push257", 3'd1, 8'hC3, 10'h000, 0, 1'b0);
        run_op("clr_ovf", 3'd6, 8'h00, 10'h000, 1, 1'b0);

        run_op("ldsp_e", 3'd5, 8'h00, 10'h000, 0, 1'b0);
        run_op("pop_clr_same", 3'd4, 8'h00, 10'h000, 2, 1'b0);
        run_op("push_clr", 3'd3, 8'h00, 10'h1FF, 1, 1'b0);

        // Asynchronous reset while the pop sits in its capture cycle.
        bus.SC_START = 1'b1;
        bus.SC_OP    = 3'd2;
        @(negedge clk);
        bus.SC_START = 1'b0;
        @(negedge clk);
        chk("abort/in_cap", 32'(bus.SC_BUSY), 32'(1));
        #2 rst = 1'b1;
        #1;
        chk_outs("abort", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("abort/rdata", 32'(bus.SC_RDATA_OUT), 32'(0));
        chk("abort/ovf",   32'(bus.SC_OVF), 32'(0));
        chk("abort/unf",   32'(bus.SC_UNF), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        m_sp = 0; m_occ = 0; m_ovf = 1'b0; m_unf = 1'b0; m_last = '0;
        @(negedge clk);
        chk_idle("post_abort");
        run_op("push_after_rst", 3'd1, 8'h81, 10'h000, 0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            logic [2:0] rop;
            int cm;
            rop = 3'($urandom_range(0, 7));
            cm  = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 2));
            run_op("rand", rop, 8'($urandom), 10'($urandom), cm, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Sequencer for the 8-bit stack pointer and the scratch RAM in the RAT CPU.
- Accepts one stack operation at a time from the control unit: PUSH, POP, CALL, RET or LDSP.
- Drives the stack pointer's INC/DEC/LD strobes and the scratch RAM address, write enable and write data in the correct cycle order.
- Tracks stack occupancy, flags overflow/underflow, and returns popped data with a valid strobe.

Parameters:
- DATA_W, 10, scratch RAM word width (holds a PC or a zero-extended register byte)
- SP_W, 8, stack pointer and scratch address width; stack depth is 2**SP_W

Ports:
- SC_CLK  in  1  clock, rising edge
- SC_RST  in  1  asynchronous reset, active-high
- SC_START  in  1  request strobe; sampled only in IDLE
- SC_OP  in  3  op code: 001 PUSH, 010 POP, 011 CALL, 100 RET, 101 LDSP, others NOP
- SC_DIN_REG  in  8  register data for PUSH/LDSP
- SC_PC  in  DATA_W  return address for CALL
- SC_SP  in  SP_W  current stack pointer value
- SC_SP_INC  out  1  stack pointer increment strobe
- SC_SP_DEC  out  1  stack pointer decrement strobe
- SC_SP_LD  out  1  stack pointer load strobe
- SC_SP_DIN  out  SP_W  stack pointer load value
- SC_SCR_ADDR  out  SP_W  scratch RAM address
- SC_SCR_WE  out  1  scratch RAM write enable
- SC_SCR_WDATA  out  DATA_W  scratch RAM write data
- SC_SCR_RDATA  in  DATA_W  scratch RAM read data, 1-cycle synchronous read
- SC_CLR_ERR  in  1  clears sticky error flags
- SC_BUSY  out  1  high in every state except IDLE
- SC_DONE  out  1  one-cycle pulse at completion of every accepted op
- SC_RDATA_OUT  out  DATA_W  last popped word, held until the next POP/RET
- SC_RDATA_VLD  out  1  pulse with SC_DONE for POP/RET
- SC_OVF  out  1  sticky overflow flag
- SC_UNF  out  1  sticky underflow flag

Behaviour:
- Reset (asynchronous): state goes to IDLE; all outputs go to 0; occupancy counter OCC (SP_W+1 bits) goes to 0. Reset mid-operation aborts the op with no DONE and drops all strobes immediately.
- All strobes decode from the registered state. Outputs are 0 in IDLE and in any state where they are not listed.
- SC_START is accepted when IDLE and SC_START=1; the op is latched with its data operand. SC_START while BUSY is ignored.
- States: IDLE, PUSH, POP_ADDR, POP_CAP, POP_DONE, LOAD, NOP_DONE.
- PUSH/CALL, accepted at cycle T: PUSH state at T+1.
  - SC_SCR_ADDR = SC_SP-1 (mod 2**SP_W); SC_SCR_WE = 1.
  - SC_SCR_WDATA = zero-extended SC_DIN_REG (PUSH) or SC_PC (CALL).
  - SC_SP_DEC = 1; OCC += 1; SC_DONE = 1; return to IDLE at T+2.
- POP/RET, accepted at T:
  - POP_ADDR at T+1: SC_SCR_ADDR = SC_SP; SC_SP_INC = 1; OCC -= 1.
  - POP_CAP at T+2: SC_RDATA_OUT register loads SC_SCR_RDATA at end of cycle.
  - POP_DONE at T+3: SC_DONE = 1; SC_RDATA_VLD = 1; IDLE at T+4.
- LDSP: LOAD state at T+1.
  - SC_SP_LD = 1; SC_SP_DIN = SC_DIN_REG.
  - OCC = (0 - SC_DIN_REG) mod 2**SP_W; SC_DONE = 1.
- NOP op: NOP_DONE at T+1 with SC_DONE = 1 only.
- Address arithmetic wraps mod 2**SP_W; SP 0x00 minus 1 gives address 0xFF.
- Error flags:
  - SC_CLR_ERR clears SC_OVF and SC_UNF on the next edge.
  - If a new error is detected in the same cycle as SC_CLR_ERR, the error wins and the flag stays set.

Optional Feature:
- Macro: STACK_CTRL_GUARD_EN.
- Defined:
  - PUSH/CALL with OCC = 2**SP_W: SC_SCR_WE = 0 and SC_SP_DEC = 0; SC_OVF set; OCC unchanged; SC_DONE still pulses at T+1.
  - POP/RET with OCC = 0: SC_SP_INC = 0; SC_SCR_ADDR = SC_SP; SC_RDATA_OUT loads 0; SC_UNF set; OCC unchanged; DONE/VLD at T+3 as normal.
- Undefined:
  - No checks; ops always execute and SP wraps.
  - OCC is still maintained mod 2**(SP_W+1).
  - SC_OVF and SC_UNF are tied to 0.

Test Plan:
- Reset, then PUSH with SC_SP=0x00, SC_DIN_REG=0x5A -> at T+1: ADDR=0xFF, WE=1, WDATA=0x05A, DEC=1, DONE=1; BUSY low at T+2.
- CALL with SC_PC=0x3A7, SP=0xFF, then RET with SP=0xFE and RAM returning 0x3A7 -> CALL writes 0x3A7 at 0xFE; RET gives INC at T+1 and RDATA_OUT=0x3A7 with DONE+VLD at T+3.
- START pulsed for a POP while a POP is in progress -> second request ignored; exactly one INC and one DONE.
- LDSP 0xF0 -> LD=1, SP_DIN=0xF0, OCC=16. Then 16 POPs without underflow; 17th POP (GUARD_EN) -> no INC, RDATA_OUT=0, UNF=1. Then SC_CLR_ERR -> UNF=0.
- GUARD_EN: 256 PUSHes from SP=0x00, then a 257th -> no WE/DEC, OVF=1, DONE pulses. Without GUARD_EN: the 257th writes address 0xFF and OVF stays 0.
- Assert SC_RST during POP_CAP -> all outputs 0 asynchronously, no DONE; state IDLE; next PUSH behaves normally.
